// File: rtl/mix_state_serializer_if.sv
// Capture/stream bus between the mixing core, the serializer and the downstream sink.
//
// Handshake semantics (both directions):
//   A capture happens on a posedge where in_valid && in_ready. in_valid is a
//   one-cycle pulse from the mixer, which cannot stall, so a pulse seen while
//   in_ready is low is lost (and counted by the serializer).
//   A beat transfers on a posedge where out_valid && out_ready. Once out_valid
//   is high it stays high, with out_data/out_idx/out_last stable, until that
//   transfer happens; it never depends combinationally on out_ready.
interface mix_state_serializer_if #(
    parameter int W      = 32,
    parameter int NWORDS = 8
);
    logic                  in_valid;
    logic [NWORDS*W-1:0]   in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_data;
    logic [3:0]            out_idx;
    logic                  out_last;

    // Producer/sink side (mixer and downstream consumer).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    // Serializer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/mix_state_serializer.sv
// Snapshots the packed mixer state on a capture pulse and streams it out one
// word per beat, optionally followed by a mod-2^W checksum beat. Captures
// offered while a stream is in flight are dropped and counted (saturating).
module mix_state_serializer #(
    parameter int W        = 32,
    parameter int NWORDS   = 8,
    parameter bit CKSUM_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mix_state_serializer_if.slave  bus,
    output logic [15:0]            drop_cnt,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CKSUM = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);
    localparam logic [3:0] CK_IDX   = 4'(NWORDS);

    state_t                state_q, state_d;
    logic [NWORDS*W-1:0]   snap_q, snap_d;
    logic [W-1:0]          cksum_q, cksum_d;
    logic                  valid_q, valid_d;
    logic [W-1:0]          data_q, data_d;
    logic [3:0]            idx_q, idx_d;
    logic                  last_q, last_d;
    logic [15:0]           drop_q, drop_d;
    logic [W-1:0]          in_sum;
    logic [3:0]            nxt_idx;

    // Checksum of the incoming snapshot, wrapping mod 2^W.
    always_comb begin
        in_sum = '0;
        for (int k = 0; k < NWORDS; k++) begin
            in_sum = in_sum + bus.in_data[k*W +: W];
        end
    end

    // Next-state and next-beat logic; every register holds unless a capture or transfer moves it.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cksum_d = cksum_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        nxt_idx = idx_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    snap_d  = bus.in_data;
                    cksum_d = in_sum;
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = bus.in_data[W-1:0];
                    idx_d   = 4'd0;
                    last_d  = 1'b0;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        if (CKSUM_EN) begin
                            state_d = CKSUM;
                            data_d  = cksum_q;
                            idx_d   = CK_IDX;
                            last_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            data_d  = '0;
                            idx_d   = 4'd0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        idx_d  = nxt_idx;
                        data_d = snap_q[32'(nxt_idx)*W +: W];
                        last_d = !CKSUM_EN && (nxt_idx == LAST_IDX);
                    end
                end
            end
            CKSUM: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    idx_d   = 4'd0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                idx_d   = 4'd0;
                last_d  = 1'b0;
            end
        endcase
    end

    // A capture pulse that arrives outside IDLE is lost; count it, stopping at all-ones.
    always_comb begin
        drop_d = drop_q;
        if (bus.in_valid && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State, snapshot and output registers; reset abandons any stream in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cksum_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= 4'd0;
            last_q  <= 1'b0;
            drop_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cksum_q <= cksum_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign drop_cnt      = drop_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mix_state_serializer.sv
// Bench for mix_state_serializer: a checksum-enabled instance (a) and a
// data-only instance (b), a beat scoreboard per instance, a vector table and
// hand-written multi-cycle sequences.
module tb_mix_state_serializer;

    localparam int W  = 32;
    localparam int NW = 8;
    localparam int BW = W + 5;

    logic clk;
    logic rst_n;
    logic [15:0] drop_a, drop_b;
    logic [1:0]  st_a, st_b;

    mix_state_serializer_if #(.W(W), .NWORDS(NW)) bus_a ();
    mix_state_serializer_if #(.W(W), .NWORDS(NW)) bus_b ();

    mix_state_serializer #(.W(W), .NWORDS(NW), .CKSUM_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .drop_cnt(drop_a), .state_dbg(st_a)
    );
    mix_state_serializer #(.W(W), .NWORDS(NW), .CKSUM_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .drop_cnt(drop_b), .state_dbg(st_b)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random, 3: never
    logic [15:0] exp_drop_a = 16'd0;
    logic [BW-1:0] exp_qa[$];
    logic [BW-1:0] exp_qb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] beat(input logic last, input logic [3:0] idx, input logic [W-1:0] d);
        return {last, idx, d};
    endfunction

    function automatic logic [NW*W-1:0] seq(input logic [W-1:0] base);
        logic [NW*W-1:0] r;
        for (int k = 0; k < NW; k++) r[k*W +: W] = base + k[W-1:0];
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input int n);
        int s;
        s = int'(a) + n;
        return (s > 65535) ? 16'hFFFF : s[15:0];
    endfunction

    // ---------------- drivers ----------------
    initial begin
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus_a.out_ready = 1'b1;
                1: bus_a.out_ready = ~bus_a.out_ready;
                2: bus_a.out_ready = 1'($urandom_range(0, 1));
                default: bus_a.out_ready = 1'b0;
            endcase
            bus_b.out_ready = 1'b1;
        end
    end

    task automatic capture_a(input logic [NW*W-1:0] d, input logic [W-1:0] ck);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
        for (int k = 0; k < NW; k++) exp_qa.push_back(beat(1'b0, 4'(k), d[k*W +: W]));
        exp_qa.push_back(beat(1'b1, 4'(NW), ck));
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic capture_b(input logic [NW*W-1:0] d);
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = d;
        for (int k = 0; k < NW; k++) exp_qb.push_back(beat(k == NW - 1, 4'(k), d[k*W +: W]));
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic wait_done_a(input string name, input int limit);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            #1;
            if (exp_qa.size() == 0 && bus_a.in_ready && !bus_a.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    // ---------------- scoreboards ----------------
    logic [BW-1:0] cur_a, held_a, cur_b;
    bit hold_a = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_a = 1'b0;
        end else begin
            cur_a = {bus_a.out_last, bus_a.out_idx, bus_a.out_data};
            if (hold_a) begin
                check("hold_valid_a", 64'(bus_a.out_valid), 64'd1);
                check("hold_beat_a", 64'(cur_a), 64'(held_a));
            end
            if (!bus_a.out_valid) check("idle_data_a", 64'(bus_a.out_data), 64'd0);
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (exp_qa.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_beat_a: got %h expected no beat", cur_a);
                end else begin
                    check("beat_a", 64'(cur_a), 64'(exp_qa.pop_front()));
                end
            end
            hold_a = bus_a.out_valid && !bus_a.out_ready;
            held_a = cur_a;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
            cur_b = {bus_b.out_last, bus_b.out_idx, bus_b.out_data};
            if (exp_qb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_beat_b: got %h expected no beat", cur_b);
            end else begin
                check("beat_b", 64'(cur_b), 64'(exp_qb.pop_front()));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct {
        string            name;
        logic [NW*W-1:0]  data;
        logic [W-1:0]     cksum;
        int               mode;
    } vec_t;

    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        logic [NW*W-1:0] d;

        vecs[0] = '{"seq_ready",    seq(32'd1), 32'h0000_0024, 0};
        vecs[1] = '{"seq_toggle",   seq(32'd1), 32'h0000_0024, 1};
        vecs[2] = '{"all_ones",     {NW{32'hFFFF_FFFF}}, 32'hFFFF_FFF8, 2};
        d = '0;
        d[0*W +: W] = 32'h8000_0000;
        d[1*W +: W] = 32'h8000_0000;
        d[7*W +: W] = 32'h0000_0005;
        vecs[3] = '{"carry_out",    d, 32'h0000_0005, 2};

        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_b.in_valid = 1'b0;
        bus_b.in_data  = '0;
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
        check("rst_out_idx", 64'(bus_a.out_idx), 64'd0);
        check("rst_out_last", 64'(bus_a.out_last), 64'd0);
        check("rst_drop", 64'(drop_a), 64'd0);
        check("rst_state", 64'(st_a), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Words 1..8 at full rate: 9 consecutive beats, ready again right after.
        ready_mode = 0;
        capture_a(seq(32'd1), 32'h24);
        check("t1_first_valid", 64'(bus_a.out_valid), 64'd1);
        check("t1_first_idx", 64'(bus_a.out_idx), 64'd0);
        check("t1_first_data", 64'(bus_a.out_data), 64'd1);
        check("t1_busy", 64'(bus_a.in_ready), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        check("t1_ck_idx", 64'(bus_a.out_idx), 64'd8);
        check("t1_ck_last", 64'(bus_a.out_last), 64'd1);
        check("t1_ck_busy", 64'(bus_a.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t1_ready_after", 64'(bus_a.in_ready), 64'd1);
        check("t1_valid_after", 64'(bus_a.out_valid), 64'd0);
        check("t1_drained", 64'(exp_qa.size()), 64'd0);

        // Table: various snapshots and sink back-pressure patterns.
        for (int i = 0; i < 4; i++) begin
            ready_mode = vecs[i].mode;
            capture_a(vecs[i].data, vecs[i].cksum);
            wait_done_a({"done_", vecs[i].name}, 200);
        end
        ready_mode = 0;
        check("table_drop", 64'(drop_a), 64'(exp_drop_a));

        // Three captures offered mid-stream are dropped and leave the stream intact.
        capture_a(seq(32'd1), 32'h24);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = seq(32'hDEAD_0000);
            @(posedge clk);
            #1;
            bus_a.in_valid = 1'b0;
        end
        exp_drop_a = sat_add(exp_drop_a, 3);
        wait_done_a("t3_done", 50);
        check("t3_drop", 64'(drop_a), 64'(exp_drop_a));

        // Capture offered in the same cycle as the final acceptance is dropped.
        capture_a(seq(32'h100), 32'h81C);
        repeat (8) @(posedge clk);
        #1;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = seq(32'hBEEF_0000);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        exp_drop_a = sat_add(exp_drop_a, 1);
        check("b2b_ready", 64'(bus_a.in_ready), 64'd1);
        check("b2b_no_capture", 64'(bus_a.out_valid), 64'd0);
        check("b2b_drop", 64'(drop_a), 64'(exp_drop_a));
        @(posedge clk);
        #1;
        check("b2b_still_idle", 64'(bus_a.out_valid), 64'd0);

        // Saturation: stall the sink and keep offering captures past 16'hFFFF.
        ready_mode = 3;
        capture_a(seq(32'h20), 32'h11C);
        bus_a.in_valid = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        exp_drop_a = sat_add(exp_drop_a, 65540);
        check("sat_drop", 64'(drop_a), 64'(exp_drop_a));
        check("sat_held_idx", 64'(bus_a.out_idx), 64'd0);
        check("sat_held_data", 64'(bus_a.out_data), 64'h20);
        ready_mode = 0;
        wait_done_a("sat_done", 50);
        check("sat_drop_after", 64'(drop_a), 64'hFFFF);

        // Asynchronous reset in the middle of beat 4.
        capture_a(seq(32'h40), 32'h21C);
        repeat (4) @(posedge clk);
        #1;
        check("t5_mid_idx", 64'(bus_a.out_idx), 64'd4);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(bus_a.out_valid), 64'd0);
        check("t5_rst_data", 64'(bus_a.out_data), 64'd0);
        check("t5_rst_idx", 64'(bus_a.out_idx), 64'd0);
        check("t5_rst_last", 64'(bus_a.out_last), 64'd0);
        check("t5_rst_ready", 64'(bus_a.in_ready), 64'd1);
        check("t5_rst_drop", 64'(drop_a), 64'd0);
        exp_qa.delete();
        exp_qb.delete();
        exp_drop_a = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        capture_a(seq(32'h10), 32'h9C);
        check("t5_restart_valid", 64'(bus_a.out_valid), 64'd1);
        check("t5_restart_idx", 64'(bus_a.out_idx), 64'd0);
        check("t5_restart_data", 64'(bus_a.out_data), 64'h10);
        wait_done_a("t5_done", 50);

        // Data-only instance: 8 beats, last on idx 7, no checksum beat.
        capture_b(seq(32'd1));
        check("t6_first_idx", 64'(bus_b.out_idx), 64'd0);
        check("t6_first_data", 64'(bus_b.out_data), 64'd1);
        repeat (7) @(posedge clk);
        #1;
        check("t6_last_idx", 64'(bus_b.out_idx), 64'd7);
        check("t6_last_flag", 64'(bus_b.out_last), 64'd1);
        check("t6_busy", 64'(bus_b.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t6_valid_after", 64'(bus_b.out_valid), 64'd0);
        check("t6_ready_after", 64'(bus_b.in_ready), 64'd1);
        check("t6_drained", 64'(exp_qb.size()), 64'd0);
        @(posedge clk);
        #1;
        check("t6_no_cksum", 64'(bus_b.out_valid), 64'd0);
        check("t6_drop", 64'(drop_b), 64'd0);
        check("final_drop_a", 64'(drop_a), 64'(exp_drop_a));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
